// File: rtl/display_scheduler_if.sv
// Bundle between game logic (master) and the display scheduler (slave).
interface display_scheduler_if #(
    parameter int unsigned SCORE_W = 14
);
    logic [SCORE_W-1:0] score_bin;
    logic               score_load;
    logic               msg_req;
    logic [15:0]        msg_code;
    logic               msg_ack;
    logic [3:0]         digit3;
    logic [3:0]         digit2;
    logic [3:0]         digit1;
    logic [3:0]         digit0;
    logic               src;
    logic               busy;

    modport master (
        output score_bin, score_load, msg_req, msg_code,
        input  msg_ack, digit3, digit2, digit1, digit0, src, busy
    );

    modport slave (
        input  score_bin, score_load, msg_req, msg_code,
        output msg_ack, digit3, digit2, digit1, digit0, src, busy
    );
endinterface

// File: rtl/display_scheduler.sv
// Shares the 4-digit display between the BCD-converted score and timed messages.
module display_scheduler #(
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned HOLD_TICKS = 50_000_000,
    parameter int unsigned TICK_W     = 26,
    parameter int unsigned BLANK_LZ   = 1
) (
    input logic                clk,
    input logic                rst,
    display_scheduler_if.slave bus
);
    localparam int unsigned       CNT_W      = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] SAT_VAL   = SCORE_W'(9999);
    localparam logic [TICK_W-1:0] HOLD_LOAD  = TICK_W'(HOLD_TICKS - 1);
    localparam logic [15:0]       RST_DIGITS = (BLANK_LZ != 0) ? 16'hFFF0 : 16'h0000;

    typedef enum logic [1:0] {CIdle, CShift, CCommit} conv_state_e;
    typedef enum logic       {AScore, AMsg} arb_state_e;

    conv_state_e conv_state_q, conv_state_d;
    arb_state_e  arb_state_q, arb_state_d;

    logic [SCORE_W-1:0]    sh_bin_q;
    logic [15:0]           sh_bcd_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [15:0]           score_bcd_q;
    logic [SCORE_W-1:0]    pend_q;
    logic                  pend_vld_q;
    logic [TICK_W-1:0]     hold_q;
    logic [15:0]           msg_q;
    logic                  ack_q;
    logic [15:0]           digits_q, digits_d;

    logic [SCORE_W-1:0]    load_val;
    logic                  conv_start;
    logic [SCORE_W-1:0]    conv_val;
    logic [15:0]           bcd_adj;
    logic [16+SCORE_W-1:0] shift_vec;
    logic                  blank3, blank2, blank1;

    // Saturate before conversion, and build one double-dabble step (add-3, then shift).
    always_comb begin
        load_val = (32'(bus.score_bin) > 32'd9999) ? SAT_VAL : bus.score_bin;
        bcd_adj  = sh_bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (sh_bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = sh_bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shift_vec = {bcd_adj, sh_bin_q} << 1;
    end

    // State registers of both FSMs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_state_q <= CIdle;
            arb_state_q  <= AScore;
        end else begin
            conv_state_q <= conv_state_d;
            arb_state_q  <= arb_state_d;
        end
    end

    // Next-state logic for converter and arbiter.
    always_comb begin
        conv_state_d = conv_state_q;
        case (conv_state_q)
            CIdle:   if (bus.score_load) conv_state_d = CShift;
            CShift:  if (bit_cnt_q == LAST_BIT) conv_state_d = CCommit;
            CCommit: conv_state_d = (bus.score_load || pend_vld_q) ? CShift : CIdle;
            default: conv_state_d = CIdle;
        endcase

        arb_state_d = arb_state_q;
        case (arb_state_q)
            AScore:  if (bus.msg_req) arb_state_d = AMsg;
            AMsg:    if (!bus.msg_req && hold_q == '0) arb_state_d = AScore;
            default: arb_state_d = AScore;
        endcase
    end

    // Decoded outputs: conversion start, busy/src/ack, and next digit values.
    always_comb begin
        // A load arriving in the commit cycle is newer than anything pending.
        conv_start = ((conv_state_q == CIdle) && bus.score_load) ||
                     ((conv_state_q == CCommit) && (bus.score_load || pend_vld_q));
        conv_val   = ((conv_state_q == CCommit) && !bus.score_load) ? pend_q : load_val;

        bus.busy    = (conv_state_q != CIdle);
        bus.src     = (arb_state_q == AMsg);
        bus.msg_ack = ack_q;

        blank3 = (BLANK_LZ != 0) && (score_bcd_q[15:12] == 4'd0);
        blank2 = blank3 && (score_bcd_q[11:8] == 4'd0);
        blank1 = blank2 && (score_bcd_q[7:4] == 4'd0);

        // Digits follow the next arbiter state so they line up with src.
        if (arb_state_d == AMsg) begin
            digits_d = bus.msg_req ? bus.msg_code : msg_q;
        end else begin
            digits_d = {blank3 ? 4'hF : score_bcd_q[15:12],
                        blank2 ? 4'hF : score_bcd_q[11:8],
                        blank1 ? 4'hF : score_bcd_q[7:4],
                        score_bcd_q[3:0]};
        end
    end

    // Converter datapath: shift registers, committed score and one-deep pending slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_bin_q    <= '0;
            sh_bcd_q    <= '0;
            bit_cnt_q   <= '0;
            score_bcd_q <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
        end else begin
            if (conv_start) begin
                sh_bin_q  <= conv_val;
                sh_bcd_q  <= '0;
                bit_cnt_q <= '0;
            end else if (conv_state_q == CShift) begin
                sh_bcd_q  <= shift_vec[SCORE_W +: 16];
                sh_bin_q  <= shift_vec[SCORE_W-1:0];
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (conv_state_q == CCommit) begin
                score_bcd_q <= sh_bcd_q;
            end
            if (conv_start) begin
                pend_vld_q <= 1'b0;
            end else if (bus.score_load) begin
                pend_q     <= load_val;
                pend_vld_q <= 1'b1;
            end
        end
    end

    // Arbiter datapath: message latch, ack pulse, hold counter, registered digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q    <= '0;
            ack_q    <= 1'b0;
            hold_q   <= '0;
            digits_q <= RST_DIGITS;
        end else begin
            digits_q <= digits_d;
            if (bus.msg_req) begin
                msg_q  <= bus.msg_code;
                ack_q  <= 1'b1;
                hold_q <= HOLD_LOAD;
            end else begin
                ack_q <= 1'b0;
                if ((arb_state_q == AMsg) && (hold_q != '0)) begin
                    hold_q <= hold_q - 1'b1;
                end
            end
        end
    end

    assign bus.digit3 = digits_q[15:12];
    assign bus.digit2 = digits_q[11:8];
    assign bus.digit1 = digits_q[7:4];
    assign bus.digit0 = digits_q[3:0];
endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with HOLD_TICKS=8.
module tb_display_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scheduler_if #(.SCORE_W(14)) bus ();

    display_scheduler #(
        .SCORE_W   (14),
        .HOLD_TICKS(8),
        .TICK_W    (4),
        .BLANK_LZ  (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [13:0] score;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[9];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] sb_q[$];
    logic [15:0] shown;

    function automatic logic [15:0] digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare against the scoreboard whenever the displayed value changes.
    task automatic sb_compare(input string name);
        logic [15:0] e;
        if (digits() !== shown && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(name, digits(), e);
            shown = e;
        end
    endtask

    task automatic do_convert(input logic [13:0] v, input logic [15:0] exp, input string tag);
        int n;
        logic [15:0] e;
        bus.score_bin  = v;
        bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
        sb_q.push_back(exp);
        check({tag, " busy_set"}, bus.busy, 1);
        n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        check({tag, " busy_cycles"}, n, 15);
        check({tag, " old_digits"}, digits(), shown);
        tick();
        e = sb_q.pop_front();
        check({tag, " digits"}, digits(), e);
        shown = e;
    endtask

    task automatic do_msg(input logic [15:0] code, input string tag);
        int n, acks, bad;
        bus.msg_code = code;
        bus.msg_req  = 1'b1;
        tick();
        bus.msg_req = 1'b0;
        check({tag, " ack"}, bus.msg_ack, 1);
        n = 0; acks = 0; bad = 0;
        while (bus.src && n < 40) begin
            n++;
            acks += int'(bus.msg_ack);
            if (digits() !== code) bad++;
            tick();
        end
        check({tag, " hold_cycles"}, n, 8);
        check({tag, " ack_count"}, acks, 1);
        check({tag, " msg_digits"}, bad, 0);
        check({tag, " back_to_score"}, digits(), shown);
    endtask

    initial begin
        int n, acks, bad;
        logic [15:0] e;
        vecs[0] = '{14'd1234,  16'h1234};
        vecs[1] = '{14'd7,     16'hFFF7};
        vecs[2] = '{14'd0,     16'hFFF0};
        vecs[3] = '{14'd9999,  16'h9999};
        vecs[4] = '{14'd12000, 16'h9999};
        vecs[5] = '{14'd10,    16'hFF10};
        vecs[6] = '{14'd305,   16'hF305};
        vecs[7] = '{14'd16383, 16'h9999};
        vecs[8] = '{14'd1000,  16'h1000};

        rst = 1'b1;
        bus.score_bin = '0; bus.score_load = 1'b0;
        bus.msg_req = 1'b0; bus.msg_code = '0;
        shown = 16'hFFF0;
        tick();
        tick();
        check("reset digits", digits(), 16'hFFF0);
        check("reset src", bus.src, 0);
        check("reset busy", bus.busy, 0);
        check("reset ack", bus.msg_ack, 0);
        rst = 1'b0;
        tick();

        // T2: table of conversions, including saturation and blanking.
        for (int i = 0; i < 9; i++) do_convert(vecs[i].score, vecs[i].exp, $sformatf("T2[%0d]", i));

        // T3: saturated load, then a newer load while busy.
        bus.score_bin = 14'd12000; bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
        sb_q.push_back(16'h9999);
        repeat (3) tick();
        bus.score_bin = 14'd42; bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
        sb_q.push_back(16'hFF42);
        n = 4;
        while (bus.busy && n < 80) begin
            tick();
            n++;
            sb_compare("T3 digits");
        end
        check("T3 busy_cycles", n, 30);
        tick();
        sb_compare("T3 digits");
        check("T3 sb_empty", sb_q.size(), 0);

        // T4: single message.
        do_msg(16'hABCD, "T4");

        // T5: retrigger at hold cycle 5, with a score committed during the message.
        bus.score_bin = 14'd55; bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
        sb_q.push_back(16'hFF55);
        repeat (3) tick();
        bus.msg_code = 16'hABCD; bus.msg_req = 1'b1;
        tick();
        bus.msg_req = 1'b0;
        check("T5 ack1", bus.msg_ack, 1);
        check("T5 src", bus.src, 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (digits() !== 16'hABCD) bad++;
            if (i < 4) tick();
        end
        check("T5 first_msg", bad, 0);
        bus.msg_code = 16'h1111; bus.msg_req = 1'b1;
        tick();
        bus.msg_req = 1'b0;
        n = 0; acks = 0; bad = 0;
        while (bus.src && n < 40) begin
            n++;
            acks += int'(bus.msg_ack);
            if (digits() !== 16'h1111) bad++;
            tick();
        end
        check("T5 hold_cycles", n, 8);
        check("T5 ack_count", acks, 1);
        check("T5 msg_digits", bad, 0);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 16'h0BAD;
        check("T5 score_after", digits(), e);
        shown = e;
        check("T5 busy", bus.busy, 0);

        // T6: asynchronous reset during conversion and message.
        bus.score_bin = 14'd8888; bus.score_load = 1'b1;
        tick();
        bus.score_load = 1'b0;
        bus.msg_code = 16'h5A5A; bus.msg_req = 1'b1;
        tick();
        bus.msg_req = 1'b0;
        repeat (3) tick();
        #3 rst = 1'b1;
        #1;
        check("T6 rst digits", digits(), 16'hFFF0);
        check("T6 rst src", bus.src, 0);
        check("T6 rst busy", bus.busy, 0);
        check("T6 rst ack", bus.msg_ack, 0);
        tick();
        rst = 1'b0;
        shown = 16'hFFF0;
        sb_q.delete();
        repeat (20) tick();
        check("T6 idle digits", digits(), 16'hFFF0);
        check("T6 idle busy", bus.busy, 0);
        do_convert(14'd7, 16'hFFF7, "T6 conv");
        do_msg(16'h0042, "T6 msg");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
